// File: rtl/uart_loader_pkg.sv
// Shared types and protocol constants for the serial firmware loader.
// Frame layout: SYNC, CNT_L, CNT_H, CNT*4 little-endian payload bytes, CHK.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT0,
    CNT1,
    DATA,
    CHK,
    REPLY
  } state_t;

  localparam logic [7:0] SYNC          = 8'hA5;
  localparam logic [7:0] ACK           = 8'h06;
  localparam logic [7:0] NAK           = 8'h15;
  localparam int         MAX_WORDS_DEF = 4096;

endpackage

// File: rtl/uart_loader.sv
// Serial firmware loader: assembles LE words from the UART and writes them into
// code RAM while holding the CPU in reset, then answers with ACK or NAK.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_d,
  output logic        mem_wr,
  output logic        cpu_resetq,
  output logic        loading,
  output logic        error
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  state_t      state, next;
  logic        rd_hold;
  logic        accept;
  logic [15:0] cnt;
  logic [15:0] cnt_rx;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic [11:0] word_idx;
  logic        last_word;

  // buart needs a cycle to drop rx_valid after a read, so that cycle is skipped
  assign accept    = load_req & rx_valid & ~rd_hold & (state != REPLY);
  assign rx_rd     = accept;
  assign cnt_rx    = {rx_data, cnt[7:0]};
  assign last_word = ({4'b0000, word_idx} == (cnt - 16'd1));
  assign mem_addr  = {2'b00, word_idx, 2'b00};
  assign loading   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetq) state <= IDLE;
    else         state <= next;
  end

  always_comb begin
    next  = state;
    tx_wr = 1'b0;
    if (!load_req) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE:  if (accept && rx_data == SYNC) next = CNT0;
        CNT0:  if (accept) next = CNT1;
        CNT1: begin
          if (accept) begin
            if (cnt_rx == 16'd0)                 next = CHK;
            else if ({1'b0, cnt_rx} > MAX_CNT)   next = REPLY;
            else                                 next = DATA;
          end
        end
        DATA:  if (accept && byte_idx == 2'd3 && last_word) next = CHK;
        CHK:   if (accept) next = REPLY;
        REPLY: begin
          if (!tx_busy) begin
            tx_wr = 1'b1;
            next  = IDLE;
          end
        end
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      rd_hold    <= 1'b0;
      cnt        <= '0;
      sum        <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      mem_d      <= '0;
      mem_wr     <= 1'b0;
      tx_data    <= '0;
      cpu_resetq <= 1'b0;
      error      <= 1'b0;
    end else begin
      rd_hold    <= accept;
      mem_wr     <= 1'b0;
      cpu_resetq <= ~load_req & (state == IDLE);
      if (mem_wr) word_idx <= word_idx + 12'd1;
      if (!load_req) begin
        // abort: words already written stay, no reply is sent
        if (state != IDLE) error <= 1'b1;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC) begin
              error    <= 1'b0;
              sum      <= '0;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
          CNT0: begin
            cnt[7:0] <= rx_data;
            sum      <= sum + rx_data;
          end
          CNT1: begin
            cnt[15:8] <= rx_data;
            sum       <= sum + rx_data;
            if ({1'b0, cnt_rx} > MAX_CNT) begin
              error   <= 1'b1;
              tx_data <= NAK;
            end
          end
          DATA: begin
            mem_d[{byte_idx, 3'b000} +: 8] <= rx_data;
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) mem_wr <= 1'b1;
          end
          CHK: begin
            if (rx_data == sum) begin
              tx_data <= ACK;
            end else begin
              tx_data <= NAK;
              error   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
